// File: rtl/window_unload_8_pkg.sv
// Shared definitions for the window pipeline: depth, beat-index type and FSM encoding.
// Used by the shift register, this unloader and the feature unit.
package window_unload_8_pkg;

    localparam int WIN_DEPTH = 8;
    localparam int IDX_W     = 3;

    typedef logic [IDX_W-1:0] idx_t;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_SEND = 1'b1;

    function automatic logic is_last(input idx_t idx);
        return idx == idx_t'(WIN_DEPTH - 1);
    endfunction

endpackage

// File: rtl/window_unload_8_if.sv
// Serial valid/ready word stream from the window unloader to the feature unit.
interface window_unload_8_if #(
    parameter int INPUT_WIDTH = 37
) ();
    import window_unload_8_pkg::*;

    logic signed [INPUT_WIDTH-1:0] dout;
    logic                          dout_valid;
    logic                          dout_ready;
    logic                          dout_last;
    idx_t                          dout_idx;

    modport master (
        output dout,
        output dout_valid,
        output dout_last,
        output dout_idx,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  dout_last,
        input  dout_idx,
        output dout_ready
    );

endinterface

// File: rtl/window_unload_8_sum_tree_8.sv
// Combinational 8-input signed adder tree; every input is sign-extended to SUM_WIDTH
// before the first level so no level can wrap.
module sum_tree_8
    import window_unload_8_pkg::*;
#(
    parameter int INPUT_WIDTH = 37,
    parameter int SUM_WIDTH   = INPUT_WIDTH + 3
) (
    input  logic signed [INPUT_WIDTH-1:0] din_i [WIN_DEPTH],
    output logic signed [SUM_WIDTH-1:0]   sum_o
);

    logic signed [SUM_WIDTH-1:0] ext_s  [WIN_DEPTH];
    logic signed [SUM_WIDTH-1:0] lvl1_s [WIN_DEPTH/2];
    logic signed [SUM_WIDTH-1:0] lvl2_s [WIN_DEPTH/4];

    // Three-level balanced reduction of the extended taps
    always_comb begin
        for (int k = 0; k < WIN_DEPTH; k++) begin
            ext_s[k] = SUM_WIDTH'(din_i[k]);
        end
        for (int k = 0; k < WIN_DEPTH/2; k++) begin
            lvl1_s[k] = ext_s[2*k] + ext_s[2*k+1];
        end
        for (int k = 0; k < WIN_DEPTH/4; k++) begin
            lvl2_s[k] = lvl1_s[2*k] + lvl1_s[2*k+1];
        end
        sum_o = lvl2_s[0] + lvl2_s[1];
    end

endmodule

// File: rtl/window_unload_8.sv
// Parallel-in/serial-out reader for the 8-tap window: captures on win_valid, streams
// oldest-first over valid/ready and publishes the signed window sum.
module window_unload_8
    import window_unload_8_pkg::*;
#(
    parameter int INPUT_WIDTH = 37,
    parameter int REG_DEPTH   = 8,
    parameter int SUM_WIDTH   = INPUT_WIDTH + 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en_i,
    input  logic                          win_valid_i,
    input  logic signed [INPUT_WIDTH-1:0] din_stage1_i,
    input  logic signed [INPUT_WIDTH-1:0] din_stage2_i,
    input  logic signed [INPUT_WIDTH-1:0] din_stage3_i,
    input  logic signed [INPUT_WIDTH-1:0] din_stage4_i,
    input  logic signed [INPUT_WIDTH-1:0] din_stage5_i,
    input  logic signed [INPUT_WIDTH-1:0] din_stage6_i,
    input  logic signed [INPUT_WIDTH-1:0] din_stage7_i,
    input  logic signed [INPUT_WIDTH-1:0] din_stage8_i,
    output logic                          win_ack_o,
    output logic signed [SUM_WIDTH-1:0]   win_sum_o,
    output logic                          busy_o,
    window_unload_8_if.master             dout_if
);

    logic [0:0]                    state_q, state_d;
    idx_t                          idx_q, idx_d;
    logic signed [INPUT_WIDTH-1:0] win_buf_q [REG_DEPTH];
    logic signed [INPUT_WIDTH-1:0] win_buf_d [REG_DEPTH];
    logic signed [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic signed [INPUT_WIDTH-1:0] dout_q, dout_d;
    logic                          last_q, last_d;

    logic signed [INPUT_WIDTH-1:0] taps_s [WIN_DEPTH];
    logic signed [SUM_WIDTH-1:0]   tap_sum_s;
    logic                          xfer_s, last_xfer_s, capture_s;

    // Buffer slot 0 holds the oldest tap so the stream order is simply idx order
    assign taps_s[0] = din_stage8_i;
    assign taps_s[1] = din_stage7_i;
    assign taps_s[2] = din_stage6_i;
    assign taps_s[3] = din_stage5_i;
    assign taps_s[4] = din_stage4_i;
    assign taps_s[5] = din_stage3_i;
    assign taps_s[6] = din_stage2_i;
    assign taps_s[7] = din_stage1_i;

    sum_tree_8 #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .SUM_WIDTH   (SUM_WIDTH)
    ) u_sum_tree (
        .din_i (taps_s),
        .sum_o (tap_sum_s)
    );

    // Next-state: capture in IDLE or on the last beat, otherwise advance on transfer
    always_comb begin
        xfer_s      = !en_i && (state_q == STATE_SEND) && dout_if.dout_ready;
        last_xfer_s = xfer_s && is_last(idx_q);
        capture_s   = !rst && !en_i && win_valid_i && ((state_q == STATE_IDLE) || last_xfer_s);

        state_d   = state_q;
        idx_d     = idx_q;
        win_buf_d = win_buf_q;
        sum_d     = sum_q;
        if (capture_s) begin
            win_buf_d = taps_s;
            sum_d     = tap_sum_s;
            state_d   = STATE_SEND;
            idx_d     = 3'd0;
        end else if (last_xfer_s) begin
            state_d = STATE_IDLE;
            idx_d   = 3'd0;
        end else if (xfer_s) begin
            idx_d = idx_q + 3'd1;
        end else begin
            idx_d = idx_q;
        end

        if (state_d == STATE_SEND) begin
            dout_d = win_buf_d[idx_d];
            last_d = is_last(idx_d);
        end else begin
            dout_d = {INPUT_WIDTH{1'b0}};
            last_d = 1'b0;
        end
    end

    // State, buffer and registered stream outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            idx_q   <= 3'd0;
            sum_q   <= {SUM_WIDTH{1'b0}};
            dout_q  <= {INPUT_WIDTH{1'b0}};
            last_q  <= 1'b0;
            for (int k = 0; k < REG_DEPTH; k++) begin
                win_buf_q[k] <= {INPUT_WIDTH{1'b0}};
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            dout_q    <= dout_d;
            last_q    <= last_d;
            win_buf_q <= win_buf_d;
        end
    end

    assign win_ack_o          = capture_s;
    assign win_sum_o          = sum_q;
    assign busy_o             = (state_q == STATE_SEND);
    assign dout_if.dout       = dout_q;
    assign dout_if.dout_valid = (state_q == STATE_SEND);
    assign dout_if.dout_idx   = idx_q;
    assign dout_if.dout_last  = last_q;

endmodule

// File: tb/tb_window_unload_8.sv
// Directed self-checking bench for window_unload_8.
module tb_window_unload_8;

    localparam logic signed [36:0] MIN37 = {1'b1, 36'b0};
    localparam logic signed [39:0] MIN40 = {1'b1, 39'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_i = 1'b0;
    logic win_valid_i = 1'b0;
    logic signed [36:0] taps [1:8];
    logic win_ack_o;
    logic signed [39:0] win_sum_o;
    logic busy_o;
    int pass_cnt = 0;
    int total_cnt = 0;

    window_unload_8_if #(.INPUT_WIDTH(37)) dif ();

    window_unload_8 #(.INPUT_WIDTH(37), .REG_DEPTH(8), .SUM_WIDTH(40)) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .win_valid_i  (win_valid_i),
        .din_stage1_i (taps[1]),
        .din_stage2_i (taps[2]),
        .din_stage3_i (taps[3]),
        .din_stage4_i (taps[4]),
        .din_stage5_i (taps[5]),
        .din_stage6_i (taps[6]),
        .din_stage7_i (taps[7]),
        .din_stage8_i (taps[8]),
        .win_ack_o    (win_ack_o),
        .win_sum_o    (win_sum_o),
        .busy_o       (busy_o),
        .dout_if      (dif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_taps(input int base);
        for (int k = 1; k <= 8; k++) taps[k] = 37'(base + k);
    endtask

    task automatic test_reset();
        rst = 1'b1; win_valid_i = 1'b1; set_taps(0);
        dif.dout_ready = 1'b1;
        tick(); tick(); #1;
        total_cnt++; if (win_ack_o !== 1'b0) $display("FAIL reset_ack got=%b exp=0", win_ack_o); else pass_cnt++;
        total_cnt++; if (dif.dout_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", dif.dout_valid); else pass_cnt++;
        total_cnt++; if (dif.dout !== 37'sd0) $display("FAIL reset_dout got=%0d exp=0", dif.dout); else pass_cnt++;
        total_cnt++; if (dif.dout_idx !== 3'd0) $display("FAIL reset_idx got=%0d exp=0", dif.dout_idx); else pass_cnt++;
        total_cnt++; if (dif.dout_last !== 1'b0) $display("FAIL reset_last got=%b exp=0", dif.dout_last); else pass_cnt++;
        total_cnt++; if (win_sum_o !== 40'sd0) $display("FAIL reset_sum got=%0d exp=0", win_sum_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_o); else pass_cnt++;
        rst = 1'b0; win_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_taps(0); dif.dout_ready = 1'b1; win_valid_i = 1'b1; #1;
        total_cnt++; if (win_ack_o !== 1'b1) $display("FAIL single_ack got=%b exp=1", win_ack_o); else pass_cnt++;
        tick(); win_valid_i = 1'b0; #1;
        total_cnt++; if (win_ack_o !== 1'b0) $display("FAIL single_ack_pulse got=%b exp=0", win_ack_o); else pass_cnt++;
        for (int b = 0; b < 8; b++) begin
            total_cnt++; if (dif.dout_valid !== 1'b1) $display("FAIL single_valid b=%0d got=%b exp=1", b, dif.dout_valid); else pass_cnt++;
            total_cnt++; if (dif.dout !== 37'(8 - b)) $display("FAIL single_dout b=%0d got=%0d exp=%0d", b, dif.dout, 8 - b); else pass_cnt++;
            total_cnt++; if (dif.dout_idx !== 3'(b)) $display("FAIL single_idx b=%0d got=%0d exp=%0d", b, dif.dout_idx, b); else pass_cnt++;
            total_cnt++; if (dif.dout_last !== (b == 7)) $display("FAIL single_last b=%0d got=%b", b, dif.dout_last); else pass_cnt++;
            total_cnt++; if (win_sum_o !== 40'sd36) $display("FAIL single_sum b=%0d got=%0d exp=36", b, win_sum_o); else pass_cnt++;
            tick(); #1;
        end
        total_cnt++; if (dif.dout_valid !== 1'b0) $display("FAIL single_end_valid got=%b exp=0", dif.dout_valid); else pass_cnt++;
        total_cnt++; if (dif.dout !== 37'sd0) $display("FAIL single_end_dout got=%0d exp=0", dif.dout); else pass_cnt++;
        total_cnt++; if (win_sum_o !== 40'sd36) $display("FAIL single_sum_kept got=%0d exp=36", win_sum_o); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int exp_b;
        set_taps(0);
        for (int k = 1; k <= 8; k++) taps[k] = 37'(10 * k);
        win_valid_i = 1'b1; dif.dout_ready = 1'b0;
        tick(); win_valid_i = 1'b0;
        exp_b = 0;
        for (int cyc = 0; cyc < 40 && exp_b < 8; cyc++) begin
            dif.dout_ready = ((cyc % 3) == 0); #1;
            total_cnt++; if (dif.dout_valid !== 1'b1 || dif.dout !== 37'(80 - 10 * exp_b) || dif.dout_idx !== 3'(exp_b))
                $display("FAIL bp_beat cyc=%0d got=%b/%0d/%0d exp=1/%0d/%0d", cyc, dif.dout_valid, dif.dout, dif.dout_idx, 80 - 10 * exp_b, exp_b);
            else pass_cnt++;
            tick();
            if (dif.dout_ready) exp_b++;
        end
        dif.dout_ready = 1'b1; #1;
        total_cnt++; if (exp_b !== 8) $display("FAIL bp_count got=%0d exp=8", exp_b); else pass_cnt++;
        total_cnt++; if (dif.dout_valid !== 1'b0) $display("FAIL bp_end_valid got=%b exp=0", dif.dout_valid); else pass_cnt++;
        total_cnt++; if (win_sum_o !== 40'sd360) $display("FAIL bp_sum got=%0d exp=360", win_sum_o); else pass_cnt++;
    endtask

    task automatic test_hold();
        set_taps(20); dif.dout_ready = 1'b1; win_valid_i = 1'b1;
        tick(); win_valid_i = 1'b0;
        tick(); tick(); // beats 28 and 27 transferred
        en_i = 1'b1; win_valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if (win_ack_o !== 1'b0) $display("FAIL hold_ack c=%0d got=%b exp=0", c, win_ack_o); else pass_cnt++;
            total_cnt++; if (dif.dout !== 37'sd26 || dif.dout_idx !== 3'd2 || dif.dout_valid !== 1'b1)
                $display("FAIL hold_frozen c=%0d got=%0d/%0d/%b exp=26/2/1", c, dif.dout, dif.dout_idx, dif.dout_valid);
            else pass_cnt++;
            total_cnt++; if (win_sum_o !== 40'sd196) $display("FAIL hold_sum c=%0d got=%0d exp=196", c, win_sum_o); else pass_cnt++;
            tick();
        end
        en_i = 1'b0; #1;
        total_cnt++; if (win_ack_o !== 1'b0) $display("FAIL hold_midwin_ack got=%b exp=0", win_ack_o); else pass_cnt++;
        win_valid_i = 1'b0;
        for (int b = 2; b < 8; b++) begin
            #1;
            total_cnt++; if (dif.dout !== 37'(28 - b) || dif.dout_idx !== 3'(b))
                $display("FAIL hold_resume b=%0d got=%0d/%0d exp=%0d/%0d", b, dif.dout, dif.dout_idx, 28 - b, b);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (dif.dout_valid !== 1'b0) $display("FAIL hold_end_valid got=%b exp=0", dif.dout_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        set_taps(0); dif.dout_ready = 1'b1; win_valid_i = 1'b1;
        tick(); win_valid_i = 1'b0;
        for (int b = 0; b < 7; b++) tick();
        for (int k = 1; k <= 8; k++) taps[k] = 37'sd100;
        win_valid_i = 1'b1; #1;
        total_cnt++; if (win_ack_o !== 1'b1 || dif.dout !== 37'sd1 || dif.dout_last !== 1'b1)
            $display("FAIL b2b_last got=%b/%0d/%b exp=1/1/1", win_ack_o, dif.dout, dif.dout_last);
        else pass_cnt++;
        tick(); win_valid_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            #1;
            total_cnt++; if (dif.dout_valid !== 1'b1 || dif.dout !== 37'sd100 || dif.dout_idx !== 3'(b))
                $display("FAIL b2b_beat b=%0d got=%b/%0d/%0d exp=1/100/%0d", b, dif.dout_valid, dif.dout, dif.dout_idx, b);
            else pass_cnt++;
            total_cnt++; if (win_sum_o !== 40'sd800) $display("FAIL b2b_sum b=%0d got=%0d exp=800", b, win_sum_o); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (dif.dout_valid !== 1'b0) $display("FAIL b2b_end_valid got=%b exp=0", dif.dout_valid); else pass_cnt++;
    endtask

    task automatic test_signed_extremes();
        for (int k = 1; k <= 8; k++) taps[k] = MIN37;
        dif.dout_ready = 1'b1; win_valid_i = 1'b1;
        tick(); win_valid_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            #1;
            total_cnt++; if (dif.dout !== MIN37) $display("FAIL ext_dout b=%0d got=%0d exp=%0d", b, dif.dout, MIN37); else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (win_sum_o !== MIN40) $display("FAIL ext_sum got=%0d exp=%0d", win_sum_o, MIN40); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        set_taps(0); dif.dout_ready = 1'b1; win_valid_i = 1'b1;
        tick(); win_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) tick();
        #1;
        total_cnt++; if (dif.dout_idx !== 3'd4) $display("FAIL rmid_pre_idx got=%0d exp=4", dif.dout_idx); else pass_cnt++;
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        total_cnt++; if (dif.dout_valid !== 1'b0 || dif.dout_idx !== 3'd0 || busy_o !== 1'b0)
            $display("FAIL rmid_state got=%b/%0d/%b exp=0/0/0", dif.dout_valid, dif.dout_idx, busy_o);
        else pass_cnt++;
        total_cnt++; if (win_sum_o !== 40'sd0) $display("FAIL rmid_sum got=%0d exp=0", win_sum_o); else pass_cnt++;
        set_taps(40); win_valid_i = 1'b1; #1;
        total_cnt++; if (win_ack_o !== 1'b1) $display("FAIL rmid_new_ack got=%b exp=1", win_ack_o); else pass_cnt++;
        tick(); win_valid_i = 1'b0;
        for (int b = 0; b < 8; b++) begin
            #1;
            total_cnt++; if (dif.dout !== 37'(48 - b) || dif.dout_idx !== 3'(b))
                $display("FAIL rmid_beat b=%0d got=%0d/%0d exp=%0d/%0d", b, dif.dout, dif.dout_idx, 48 - b, b);
            else pass_cnt++;
            tick();
        end
        #1;
        total_cnt++; if (win_sum_o !== 40'sd356) $display("FAIL rmid_new_sum got=%0d exp=356", win_sum_o); else pass_cnt++;
        total_cnt++; if (dif.dout_valid !== 1'b0) $display("FAIL rmid_end_valid got=%b exp=0", dif.dout_valid); else pass_cnt++;
    endtask

    initial begin
        set_taps(0);
        dif.dout_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_hold();
        test_back_to_back();
        test_signed_extremes();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/window_unload_8.md
Name: window_unload_8

Overview:
Parallel-in/serial-out reader for the 8-tap sample window produced by the window shift register. It consumes a window when the window's data_valid is high and returns a one-cycle win_ack. It then streams the 8 words oldest-first over a valid/ready interface to the downstream feature unit, and publishes the signed sum of the captured window alongside.

Parameters:
input_width, 37, bit width of each signed window word
reg_depth, 8, window depth; fixed at 8 because the tap ports are explicit
sum_width, input_width+3, width of win_sum (must hold the sum of 8 words without overflow)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
en  in  1  hold, active-low; when high, all state and outputs freeze
win_valid  in  1  window complete (the shift register's data_valid)
din_stage1..din_stage8  in  input_width each, signed  window taps; stage1 newest, stage8 oldest
win_ack  out  1  one-cycle pulse: window captured this cycle
dout  out  input_width, signed  serial word
dout_valid  out  1  dout holds a word
dout_ready  in  1  downstream accepts the word
dout_last  out  1  current word is the 8th of the window
dout_idx  out  3  beat index 0..7
win_sum  out  sum_width, signed  sum of the last captured window
busy  out  1  a window is being streamed (equals dout_valid)

Behaviour:
- Reset (synchronous, rst=1): state=IDLE; buffer cleared to 0; dout=0; dout_valid=0; dout_last=0; dout_idx=0; win_ack=0; win_sum=0. Reset during SEND aborts the window with no further beats and no ack.
- en=1 overrides everything except rst:
  - No state change, no capture, no transfer, even if dout_ready=1.
  - win_ack is forced to 0.
  - dout, dout_valid, dout_idx, dout_last and win_sum hold their values.
- FSM with two states, IDLE and SEND. All transitions below require en=0.
- Capture (win_valid=1 in IDLE):
  - Register all 8 taps into buf[0..7]; buf[0] gets din_stage8 (oldest) and buf[7] gets din_stage1.
  - Register win_sum as the sign-extended sum of the 8 taps.
  - Pulse win_ack for this cycle (combinational from state/en/win_valid).
  - Go to SEND with idx=0.
- Latency: first dout_valid is 1 cycle after the capture edge.
- SEND outputs: dout=buf[idx]; dout_valid=1; dout_idx=idx; dout_last=(idx==7).
- Transfer: a beat transfers on a cycle where dout_valid=1, dout_ready=1 and en=0.
  - If idx<7, idx increments.
  - Without a transfer, dout and its index are stable (backpressure holds indefinitely).
- Last beat (idx==7 transfers):
  - If win_valid=1 in the same cycle: back-to-back capture. Load the new window, set idx=0, pulse win_ack, stay in SEND. There is no bubble.
  - Otherwise: go to IDLE; dout_valid=0 and dout=0 from the next cycle.
- win_valid in SEND before the last beat: ignored, with no ack. The upstream shift register keeps its window, so it is re-presented.
- win_sum keeps its value until the next capture. It is not cleared on return to IDLE.
- Arithmetic: two's complement. Each tap is sign-extended to sum_width before addition, so there is no wrap for any input.
- Throughput: 8 beats per window at full rate (dout_ready=1); a window every 8 cycles with back-to-back capture.

Decomposition:
- Shared package: WIN_DEPTH=8, IDX_W=3, and the state encoding (IDLE=1'b0, SEND=1'b1), shared with the shift register and the feature unit.
- Sub-module sum_tree_8: a combinational 8-input signed adder tree, parameterised by input_width and sum_width. It is reused by the feature unit.
- Control and buffer stay in this module.

Test Plan:
- Reset then single window:
  - Stimulus: taps stage1..8 = 1,2,3,4,5,6,7,8; win_valid pulse; dout_ready=1.
  - Response: win_ack for 1 cycle; from the next cycle dout = 8,7,6,5,4,3,2,1 on 8 consecutive cycles with dout_idx 0..7; dout_last only on the word 1; win_sum=36; then dout_valid=0.
- Backpressure:
  - Stimulus: dout_ready toggles 1,0,0,1,...
  - Response: dout and dout_idx hold through the ready=0 cycles; no beat is skipped or duplicated; all 8 beats are delivered.
- Hold:
  - Stimulus: en=1 for 3 cycles mid-window (ready=1, win_valid=1).
  - Response: outputs frozen, no transfer, win_ack=0; streaming resumes at the same idx when en returns to 0.
- Back-to-back:
  - Stimulus: second window (taps all 100) with win_valid held during the last beat.
  - Response: win_ack on the last-beat cycle; the next cycle dout=100 with idx=0; dout_valid never drops; win_sum=800.
- Signed extremes:
  - Stimulus: all taps = -2^36.
  - Response: win_sum = -2^39 exactly; dout = -2^36 on every beat.
- Reset mid-window:
  - Stimulus: rst=1 at idx=4.
  - Response: next cycle dout_valid=0, dout_idx=0, win_sum=0, state IDLE; an immediate new window restarts at idx 0.
